mem_alloc_arbiter: RTL and testbench
====================================

# mem_alloc_arbiter

Shares the single block-allocator occupy/release interface among NPORT cache ports. Allocation requests are arbitrated round-robin and sequenced through a one-at-a-time request/response transaction; the returned block address goes back to the winning port. Release requests from all ports are merged round-robin, one per cycle, into the allocator's single release port. The block sits between the per-port write/read controllers and the block allocator.

## Interface
Parameters:
- NPORT, 16, number of cache ports (≥2)
- AWIDTH, 10, block address width; matches the allocator
- TMO, 15, watchdog limit in cycles for an allocator response (only used with MEM_ARB_WDOG_EN)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- alloc_req  in  NPORT  per-port allocation request; level, held until that port's grant
- alloc_gnt  out  NPORT  one-hot, one-cycle grant pulse
- alloc_addr  out  AWIDTH  granted block address; valid while alloc_gnt≠0
- rls_vld  in  NPORT  per-port release valid
- rls_addr  in  NPORT*AWIDTH  per-port release address; port i occupies bits [i*AWIDTH +: AWIDTH]
- rls_rdy  out  NPORT  one-hot, combinational accept for release
- mm_ocp_req  out  1  allocation request to the allocator
- mm_ocp_vld  in  1  allocator response valid, one-cycle pulse
- mm_ocp_addr  in  AWIDTH  allocator block address
- mm_full  in  1  allocator has no free block
- mm_rls_vld  out  1  release strobe to the allocator
- mm_rls_addr  out  AWIDTH  released block address
- busy  out  1  allocation FSM not in IDLE
- tmo_err  out  1  sticky watchdog error

## Operation
- Allocation FSM states: IDLE, REQ, WAIT, GNT.
- IDLE: if any alloc_req is set and mm_full=0, the round-robin arbiter picks a winner, which is registered. Next state is REQ. If mm_full=1, the FSM stays in IDLE and issues no request.
- REQ: mm_ocp_req=1 for exactly this one cycle; next state is WAIT.
- WAIT: mm_ocp_req=0. On mm_ocp_vld, mm_ocp_addr is registered; next state is GNT.
- GNT: alloc_gnt[winner]=1 and alloc_addr=registered address for one cycle. The allocation pointer advances to winner+1 mod NPORT; next state is IDLE.
- Round-robin means the search starts at the pointer, ascending with wrap-around. The pointer resets to 0.
- The winner always receives its grant, even if it drops alloc_req after selection. Dropping the request early is a protocol violation by the requester.
- mm_ocp_vld outside WAIT is ignored.
- Release path runs independently of the allocation FSM:
  - The release arbiter (separate pointer, same round-robin rule) picks one port among rls_vld each cycle.
  - rls_rdy[winner]=1 combinationally.
  - Next cycle: mm_rls_vld=1 and mm_rls_addr=the winner's address.
  - The release pointer advances on each accept.
- Reset values: all outputs 0, both pointers 0, state IDLE, tmo_err 0.
- Reset mid-transaction aborts it. No grant is issued; the allocator is reset by the same rst_n.

## Timing
- Allocation latency: a request sampled in IDLE at cycle c gives mm_ocp_req at c+1. Against the allocator's 2-cycle response, mm_ocp_vld arrives at c+3 and alloc_gnt at c+4.
- Maximum allocation throughput: one grant per 5 cycles against that allocator.
- Release: one accept per cycle; mm_rls_vld appears 1 cycle after rls_vld&rls_rdy.
- Simultaneous alloc and release in the same cycle are fully independent.
- With all NPORT release ports asserting continuously, each port is served once every NPORT cycles.

## Configuration
- MEM_ARB_WDOG_EN defined:
  - A counter runs in WAIT. If mm_ocp_vld has not arrived after TMO cycles, tmo_err sets (sticky until reset) and the FSM returns to IDLE.
  - No grant is issued and the pointer is not advanced, so the same port is re-arbitrated first.
- Not defined: WAIT waits indefinitely. tmo_err is tied 0; the port remains present.

## Structure
- Package mem_arb_pkg holds:
  - the FSM state enum (IDLE, REQ, WAIT, GNT);
  - the default NPORT/AWIDTH/TMO localparams;
  - the pointer width, $clog2(NPORT).
- One sub-module, rr_arbiter, instantiated twice (alloc and release). It takes NPORT request bits, a pointer and an advance strobe, and outputs a one-hot grant and a valid flag.

## Test plan
- Single request: alloc_req=0x0004, allocator returns 0x05A → alloc_gnt=0x0004, alloc_addr=0x05A exactly 4 cycles after the request; busy high for 4 cycles.
- Fairness: alloc_req=0xFFFF held, each port dropping its request on its grant → grants in order port 0,1,…,15, one every 5 cycles.
- Full: mm_full=1 with alloc_req=0x0001 → no mm_ocp_req and no grant; mm_full drops → grant 4 cycles later.
- Release merge: rls_vld=0x0013 for one cycle, each held until rdy → accepted ports 0,1,4 on consecutive cycles; mm_rls_addr sequence matches each port's address, one cycle after each accept.
- Watchdog (MEM_ARB_WDOG_EN, TMO=15): no mm_ocp_vld → tmo_err=1 15 cycles into WAIT and the FSM returns to IDLE. A late mm_ocp_vld is ignored, and the same port is re-requested.
- Reset mid-WAIT: rst_n low → all outputs 0 immediately; no grant after release of reset.

Source files
------------

// File: rtl/mem_alloc_arbiter_pkg.sv
// Shared types and defaults for the block-allocator port arbiter.
// Used by mem_alloc_arbiter and rr_arbiter.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        GNT  = 2'd3
    } arb_state_t;

    localparam int NPORT_DEF  = 16;
    localparam int AWIDTH_DEF = 10;
    localparam int TMO_DEF    = 15;

    // Round-robin pointer width for a given port count.
    function automatic int ptr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_alloc_arbiter_rr_arbiter.sv
// Round-robin arbiter: search starts at the internal pointer, ascending with wrap.
// On i_adv the pointer moves to one past i_adv_idx.
module rr_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NPORT = NPORT_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NPORT-1:0]         i_req,
    input  logic                     i_adv,
    input  logic [ptr_w(NPORT)-1:0]  i_adv_idx,
    output logic [NPORT-1:0]         o_gnt,
    output logic                     o_vld,
    output logic [ptr_w(NPORT)-1:0]  o_idx
);
    localparam int PW = ptr_w(NPORT);

    logic [PW-1:0]    r_ptr;
    logic [NPORT-1:0] w_gnt;
    logic             w_vld;
    logic [PW-1:0]    w_idx;

    always_comb begin
        int j;
        j     = 0;
        w_gnt = '0;
        w_vld = 1'b0;
        w_idx = '0;
        for (int k = 0; k < NPORT; k++) begin
            j = (int'(r_ptr) + k) % NPORT;
            if (!w_vld && i_req[j]) begin
                w_vld    = 1'b1;
                w_gnt[j] = 1'b1;
                w_idx    = PW'(j);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_adv) begin
            r_ptr <= (i_adv_idx == PW'(NPORT - 1)) ? '0 : i_adv_idx + 1'b1;
        end
    end

    assign o_gnt = w_gnt;
    assign o_vld = w_vld;
    assign o_idx = w_idx;

endmodule

// File: rtl/mem_alloc_arbiter.sv
// Shares the block allocator's occupy/release interface among NPORT cache ports.
// Optional response watchdog enabled by defining MEM_ARB_WDOG_EN.
module mem_alloc_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NPORT  = NPORT_DEF,
    parameter int AWIDTH = AWIDTH_DEF,
    parameter int TMO    = TMO_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NPORT-1:0]          alloc_req,
    output logic [NPORT-1:0]          alloc_gnt,
    output logic [AWIDTH-1:0]         alloc_addr,
    input  logic [NPORT-1:0]          rls_vld,
    input  logic [NPORT*AWIDTH-1:0]   rls_addr,
    output logic [NPORT-1:0]          rls_rdy,
    output logic                      mm_ocp_req,
    input  logic                      mm_ocp_vld,
    input  logic [AWIDTH-1:0]         mm_ocp_addr,
    input  logic                      mm_full,
    output logic                      mm_rls_vld,
    output logic [AWIDTH-1:0]         mm_rls_addr,
    output logic                      busy,
    output logic                      tmo_err
);
    localparam int PW = ptr_w(NPORT);

    arb_state_t        r_state;
    logic [PW-1:0]     r_winner;
    logic [NPORT-1:0]  r_win_oh;
    logic              r_ocp_req;
    logic [NPORT-1:0]  r_gnt;
    logic [AWIDTH-1:0] r_addr;
    logic              r_rls_vld;
    logic [AWIDTH-1:0] r_rls_addr;

    logic [NPORT-1:0]  w_a_gnt;
    logic              w_a_vld;
    logic [PW-1:0]     w_a_idx;
    logic [NPORT-1:0]  w_r_gnt;
    logic              w_r_vld;
    logic [PW-1:0]     w_r_idx;
    logic [AWIDTH-1:0] w_rls_addr;

`ifdef MEM_ARB_WDOG_EN
    localparam int TW = (TMO > 1) ? $clog2(TMO + 1) : 1;
    logic [TW-1:0] r_tmo_cnt;
    logic          r_tmo_err;
    assign tmo_err = r_tmo_err;
`else
    // Constant 0; TMO only has meaning with the watchdog built in.
    assign tmo_err = (TMO < 0);
`endif

    rr_arbiter #(.NPORT(NPORT)) u_alloc_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (alloc_req),
        .i_adv     (r_state == GNT),
        .i_adv_idx (r_winner),
        .o_gnt     (w_a_gnt),
        .o_vld     (w_a_vld),
        .o_idx     (w_a_idx)
    );

    rr_arbiter #(.NPORT(NPORT)) u_rls_arb (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_req     (rls_vld),
        .i_adv     (w_r_vld),
        .i_adv_idx (w_r_idx),
        .o_gnt     (w_r_gnt),
        .o_vld     (w_r_vld),
        .o_idx     (w_r_idx)
    );

    // The winner is latched in IDLE so a late-dropping requester still gets its grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_winner  <= '0;
            r_win_oh  <= '0;
            r_ocp_req <= 1'b0;
            r_gnt     <= '0;
            r_addr    <= '0;
`ifdef MEM_ARB_WDOG_EN
            r_tmo_cnt <= '0;
            r_tmo_err <= 1'b0;
`endif
        end else begin
            r_ocp_req <= 1'b0;
            r_gnt     <= '0;
            case (r_state)
                IDLE: begin
                    if (w_a_vld && !mm_full) begin
                        r_winner  <= w_a_idx;
                        r_win_oh  <= w_a_gnt;
                        r_ocp_req <= 1'b1;
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    r_state <= WAIT;
`ifdef MEM_ARB_WDOG_EN
                    r_tmo_cnt <= '0;
`endif
                end
                WAIT: begin
                    if (mm_ocp_vld) begin
                        r_gnt   <= r_win_oh;
                        r_addr  <= mm_ocp_addr;
                        r_state <= GNT;
                    end
`ifdef MEM_ARB_WDOG_EN
                    else if (r_tmo_cnt == TW'(TMO - 1)) begin
                        r_tmo_err <= 1'b1;
                        r_state   <= IDLE;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
                    end
`endif
                end
                GNT:     r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign w_rls_addr = rls_addr[int'(w_r_idx)*AWIDTH +: AWIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rls_vld  <= 1'b0;
            r_rls_addr <= '0;
        end else begin
            r_rls_vld <= w_r_vld;
            if (w_r_vld) begin
                r_rls_addr <= w_rls_addr;
            end
        end
    end

    assign alloc_gnt   = r_gnt;
    assign alloc_addr  = r_addr;
    assign mm_ocp_req  = r_ocp_req;
    assign busy        = (r_state != IDLE);
    assign rls_rdy     = w_r_gnt;
    assign mm_rls_vld  = r_rls_vld;
    assign mm_rls_addr = r_rls_addr;

endmodule

// File: tb/tb_mem_alloc_arbiter.sv
// Self-checking bench for mem_alloc_arbiter: table-driven allocations, randomized
// release traffic against a round-robin reference model, and multi-cycle corner cases.
module tb_mem_alloc_arbiter;
    localparam int N  = 16;
    localparam int AW = 10;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [N-1:0]      alloc_req = '0;
    logic [N-1:0]      alloc_gnt;
    logic [AW-1:0]     alloc_addr;
    logic [N-1:0]      rls_vld = '0;
    logic [N*AW-1:0]   rls_addr = '0;
    logic [N-1:0]      rls_rdy;
    logic              mm_ocp_req;
    logic              mm_ocp_vld = 1'b0;
    logic [AW-1:0]     mm_ocp_addr = '0;
    logic              mm_full = 1'b0;
    logic              mm_rls_vld;
    logic [AW-1:0]     mm_rls_addr;
    logic              busy;
    logic              tmo_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // allocator model controls
    logic          resp_en = 1'b1;
    logic [AW-1:0] resp_addr = '0;
    int            force_cnt = 0;
    int            force_seen = 0;
    int            rcnt = 0;

    // reference model state
    int            m_aptr = 0;
    int            m_rptr = 0;
    logic          prev_vld = 1'b0;
    logic [AW-1:0] prev_addr = '0;

    typedef struct {
        logic [N-1:0]  req;
        logic [AW-1:0] addr;
        int            exp_port;
    } avec_t;
    avec_t tbl[7];

    mem_alloc_arbiter #(.NPORT(N), .AWIDTH(AW), .TMO(15)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_req   (alloc_req),
        .alloc_gnt   (alloc_gnt),
        .alloc_addr  (alloc_addr),
        .rls_vld     (rls_vld),
        .rls_addr    (rls_addr),
        .rls_rdy     (rls_rdy),
        .mm_ocp_req  (mm_ocp_req),
        .mm_ocp_vld  (mm_ocp_vld),
        .mm_ocp_addr (mm_ocp_addr),
        .mm_full     (mm_full),
        .mm_rls_vld  (mm_rls_vld),
        .mm_rls_addr (mm_rls_addr),
        .busy        (busy),
        .tmo_err     (tmo_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Allocator: answers a request seen in cycle t with a one-cycle valid in cycle t+2.
    always @(negedge clk) begin
        mm_ocp_vld  = 1'b0;
        mm_ocp_addr = ~resp_addr;
        if (!rst_n) begin
            rcnt = 0;
        end else begin
            if (rcnt > 0) begin
                rcnt = rcnt - 1;
                if (rcnt == 0 && resp_en) begin
                    mm_ocp_vld  = 1'b1;
                    mm_ocp_addr = resp_addr;
                end
            end
            if (force_cnt != force_seen) begin
                force_seen  = force_cnt;
                mm_ocp_vld  = 1'b1;
                mm_ocp_addr = resp_addr;
            end
            if (mm_ocp_req) rcnt = 2;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [N-1:0] m, input int p);
        for (int k = 0; k < N; k++) begin
            if (m[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        alloc_req = '0;
        rls_vld = '0;
        mm_full = 1'b0;
        resp_en = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_aptr = 0;
        m_rptr = 0;
        prev_vld = 1'b0;
    endtask

    task automatic wait_gnt(output int n, output logic got);
        n = 0;
        got = 1'b0;
        while (!got && n < 40) begin
            @(negedge clk);
            n++;
            if (alloc_gnt != '0) got = 1'b1;
        end
    endtask

    task automatic do_alloc(input logic [N-1:0] req, input logic [AW-1:0] addr,
                            input int exp, input string nm);
        int n;
        int nb;
        logic got;
        @(negedge clk);
        alloc_req = req;
        mm_full = 1'b0;
        resp_addr = addr;
        n = 0;
        nb = 0;
        got = 1'b0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (alloc_gnt != '0) got = 1'b1;
        end
        chk({nm, "_seen"}, 32'(got), 32'd1);
        chk({nm, "_lat"}, n, 4);
        chk({nm, "_gnt"}, 32'(alloc_gnt), (exp < 0) ? 32'd0 : (32'd1 << exp));
        chk({nm, "_addr"}, 32'(alloc_addr), 32'(addr));
        chk({nm, "_busy"}, nb, 4);
        alloc_req = '0;
        if (exp >= 0) m_aptr = (exp + 1) % N;
        @(negedge clk);
        chk({nm, "_after"}, {30'd0, busy, |alloc_gnt}, 32'd0);
    endtask

    task automatic rel_cycle(input logic [N-1:0] v, input logic rnd, input string nm,
                             output int idx);
        @(negedge clk);
        if (prev_vld) begin
            chk({nm, "_mvld"}, 32'(mm_rls_vld), 32'd1);
            chk({nm, "_maddr"}, 32'(mm_rls_addr), 32'(prev_addr));
        end else begin
            chk({nm, "_mvld"}, 32'(mm_rls_vld), 32'd0);
        end
        if (rnd) begin
            for (int p = 0; p < N; p++) rls_addr[p*AW +: AW] = AW'($urandom);
        end
        rls_vld = v;
        #1;
        idx = rr_pick(v, m_rptr);
        chk({nm, "_rdy"}, 32'(rls_rdy), (idx < 0) ? 32'd0 : (32'd1 << idx));
        prev_vld = (idx >= 0);
        if (idx >= 0) begin
            prev_addr = rls_addr[idx*AW +: AW];
            m_rptr = (idx + 1) % N;
        end
    endtask

    initial begin
        int idx;
        int n;
        int last;
        int start;
        logic got;
        logic [N-1:0] hold;
        int order[3];

        tbl[0] = '{16'h0004, 10'h05A, 2};
        tbl[1] = '{16'h0003, 10'h3FF, 0};
        tbl[2] = '{16'h8002, 10'h000, 1};
        tbl[3] = '{16'h8002, 10'h155, 15};
        tbl[4] = '{16'hFFFF, 10'h2AA, 0};
        tbl[5] = '{16'h0010, 10'h0F0, 4};
        tbl[6] = '{16'h0001, 10'h00F, 0};
        order[0] = 0; order[1] = 1; order[2] = 4;

        do_reset();
        @(negedge clk);
        chk("rst_gnt", 32'(alloc_gnt), 32'd0);
        chk("rst_addr", 32'(alloc_addr), 32'd0);
        chk("rst_ocp", 32'(mm_ocp_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mrls", {21'd0, mm_rls_vld, mm_rls_addr}, 32'd0);
        chk("rst_tmo", 32'(tmo_err), 32'd0);
        chk("rst_rdy", 32'(rls_rdy), 32'd0);

        // release merge: ports 0,1,4 held until accepted
        for (int p = 0; p < N; p++) rls_addr[p*AW +: AW] = AW'(p * 7 + 3);
        rls_addr[0*AW +: AW] = 10'h011;
        rls_addr[1*AW +: AW] = 10'h122;
        rls_addr[4*AW +: AW] = 10'h3F4;
        hold = 16'h0013;
        for (int i = 0; i < 3; i++) begin
            rel_cycle(hold, 1'b0, "rls_merge", idx);
            chk("rls_order", idx, order[i]);
            if (idx >= 0) hold[idx] = 1'b0;
        end
        rel_cycle('0, 1'b0, "rls_flush", idx);

        for (int i = 0; i < 40; i++) rel_cycle(N'($urandom), 1'b1, "rls_rand", idx);
        rel_cycle('0, 1'b0, "rls_flush", idx);

        start = m_rptr;
        for (int k = 0; k < 2 * N; k++) begin
            rel_cycle('1, 1'b1, "rls_all", idx);
            chk("rls_rot", idx, (start + k) % N);
        end
        rel_cycle('0, 1'b0, "rls_flush", idx);

        for (int i = 0; i < 7; i++) do_alloc(tbl[i].req, tbl[i].addr, tbl[i].exp_port, "alloc_tbl");

        for (int i = 0; i < 6; i++) begin
            hold = N'($urandom_range(1, 65535));
            do_alloc(hold, AW'($urandom), rr_pick(hold, m_aptr), "alloc_rand");
        end

        // allocator full: no request goes out until mm_full drops
        @(negedge clk);
        mm_full = 1'b1;
        alloc_req = 16'h0001;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("full_hold", {29'd0, mm_ocp_req, |alloc_gnt, busy}, 32'd0);
        end
        do_alloc(16'h0001, 10'h2A5, rr_pick(16'h0001, m_aptr), "full_rel");

        // fairness: all ports request, each drops on its own grant
        do_reset();
        hold = '1;
        @(negedge clk);
        alloc_req = hold;
        last = 0;
        for (int k = 0; k < N; k++) begin
            resp_addr = AW'(k * 37 + 5);
            wait_gnt(n, got);
            chk("fair_seen", 32'(got), 32'd1);
            chk("fair_gnt", 32'(alloc_gnt), 32'd1 << k);
            chk("fair_addr", 32'(alloc_addr), 32'(k * 37 + 5));
            if (k > 0) chk("fair_gap", cyc - last, 5);
            last = cyc;
            hold = hold & ~alloc_gnt;
            alloc_req = hold;
        end
        alloc_req = '0;
        m_aptr = 0;

`ifdef MEM_ARB_WDOG_EN
        resp_en = 1'b0;
        @(negedge clk);
        alloc_req = 16'h0008;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (i == 16) chk("wd_pre", 32'(tmo_err), 32'd0);
            if (i == 17) begin
                chk("wd_set", 32'(tmo_err), 32'd1);
                chk("wd_idle", 32'(busy), 32'd0);
            end
        end
        alloc_req = '0;
        force_cnt++;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("wd_late", {30'd0, |alloc_gnt, busy}, 32'd0);
        end
        resp_en = 1'b1;
        do_alloc(16'h0018, 10'h1C3, rr_pick(16'h0018, m_aptr), "wd_retry");
        chk("wd_sticky", 32'(tmo_err), 32'd1);
`endif

        // reset while waiting for the allocator
        resp_en = 1'b0;
        rls_addr[2*AW +: AW] = 10'h2C7;
        @(negedge clk);
        alloc_req = 16'h0002;
        rls_vld = 16'h0004;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        rls_vld = '0;
        #1;
        chk("rstw_gnt", 32'(alloc_gnt), 32'd0);
        chk("rstw_addr", 32'(alloc_addr), 32'd0);
        chk("rstw_ocp", {30'd0, mm_ocp_req, busy}, 32'd0);
        chk("rstw_mrls", {21'd0, mm_rls_vld, mm_rls_addr}, 32'd0);
        chk("rstw_tmo", 32'(tmo_err), 32'd0);
        chk("rstw_rdy", 32'(rls_rdy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        alloc_req = '0;
        resp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rstw_quiet", {29'd0, |alloc_gnt, mm_ocp_req, busy}, 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
